// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours: hazard/redirect
// controls in, instruction-memory port, and the IF/ID register plus counters out.
interface if_fetch_stage_if;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        exc_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    // Drives controls and memory data, observes the fetch stage.
    modport master (
        output stall, jump_en, jump_target, branch_en, branch_target, exc_en,
        output imem_instr,
        input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
        input  fetch_count, stall_count
    );

    // The fetch stage itself.
    modport slave (
        input  stall, jump_en, jump_target, branch_en, branch_target, exc_en,
        input  imem_instr,
        output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid,
        output fetch_count, stall_count
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, redirect
// priority (exception > branch > stall > jump > sequential) and two
// saturating performance counters. All control is decoded per cycle.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR = 32'h80000004,
    parameter logic [31:0] NOP_INSTR  = 32'h00000000
) (
    input logic               clk,
    input logic               reset_n,
    if_fetch_stage_if.slave   bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic [31:0] pc_plus4;
    logic        redirect;
    logic        hold;
    logic        load;

    // An older (EX) branch or an exception cancels the stall; a stalled jump
    // is not taken and will be re-presented by ID.
    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = bus.exc_en | bus.branch_en | (bus.jump_en & ~bus.stall);
    assign hold     = bus.stall & ~bus.exc_en & ~bus.branch_en;
    assign load     = ~redirect & ~hold;

    // Next-PC selection by fixed priority.
    always_comb begin
        pc_d = pc_plus4;
        if (bus.exc_en)
            pc_d = EXC_VECTOR;
        else if (bus.branch_en)
            pc_d = {bus.branch_target[31:2], 2'b00};
        else if (bus.stall)
            pc_d = pc_q;
        else if (bus.jump_en)
            pc_d = {bus.jump_target[31:2], 2'b00};
    end

    // IF/ID next value: flush on redirect, hold on stall, else capture.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (redirect) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!hold) begin
            instr_d = bus.imem_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    // Saturating counter updates.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load && fetch_cnt_q != 32'hFFFFFFFF)
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (hold && stall_cnt_q != 32'hFFFFFFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.imem_addr      = pc_q;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc_plus4 = pc4_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.fetch_count    = fetch_cnt_q;
    assign bus.stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a scoreboard of expected states.
module tb_if_fetch_stage;

    localparam logic [31:0] EXC_VEC = 32'h80000004;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    logic clk;
    logic reset_n;
    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_sc;
    logic        m_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0)      return 32'h3c016261;
        else if (a == 32'h4) return 32'h34246163;
        else                 return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.imem_instr = rom(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
    endtask

    // Drive one cycle of inputs, predict the post-edge state, then compare.
    task automatic cycle(input logic st, input logic je, input logic [31:0] jt,
                         input logic be, input logic [31:0] bt, input logic ex);
        exp_t e;
        logic taken, frozen;
        bus.stall = st; bus.jump_en = je; bus.jump_target = jt;
        bus.branch_en = be; bus.branch_target = bt; bus.exc_en = ex;
        taken  = ex || be || (je && !st);
        frozen = st && !ex && !be;
        if (ex)       e.pc = EXC_VEC;
        else if (be)  e.pc = bt & 32'hFFFFFFFC;
        else if (st)  e.pc = m_pc;
        else if (je)  e.pc = jt & 32'hFFFFFFFC;
        else          e.pc = m_pc + 32'd4;
        e.fc = m_fc; e.sc = m_sc;
        if (taken) begin
            e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
        end else if (frozen) begin
            e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
            e.sc = m_sc + 32'd1;
        end else begin
            e.instr = rom(m_pc); e.pc4 = m_pc + 32'd4; e.valid = 1'b1;
            e.fc = m_fc + 32'd1;
        end
        sb.push_back(e);
        m_pc = e.pc; m_instr = e.instr; m_pc4 = e.pc4;
        m_valid = e.valid; m_fc = e.fc; m_sc = e.sc;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("imem_addr",      bus.imem_addr,            e.pc);
        check("if_id_instr",    bus.if_id_instr,          e.instr);
        check("if_id_pc_plus4", bus.if_id_pc_plus4,       e.pc4);
        check("if_id_valid",    {31'h0, bus.if_id_valid}, {31'h0, e.valid});
        check("fetch_count",    bus.fetch_count,          e.fc);
        check("stall_count",    bus.stall_count,          e.sc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  bus.imem_addr,            32'h0);
        check({tag, "_instr"}, bus.if_id_instr,          32'h0);
        check({tag, "_pc4"},   bus.if_id_pc_plus4,       32'h0);
        check({tag, "_valid"}, {31'h0, bus.if_id_valid}, 32'h0);
        check({tag, "_fc"},    bus.fetch_count,          32'h0);
        check({tag, "_sc"},    bus.stall_count,          32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.stall = 1'b0; bus.jump_en = 1'b0; bus.jump_target = 32'h0;
        bus.branch_en = 1'b0; bus.branch_target = 32'h0; bus.exc_en = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Free-running fetch from the reset PC.
        cycle(0, 0, 0, 0, 0, 0);
        check("seq1_addr",  bus.imem_addr,   32'h4);
        check("seq1_instr", bus.if_id_instr, 32'h3c016261);
        check("seq1_pc4",   bus.if_id_pc_plus4, 32'h4);
        cycle(0, 0, 0, 0, 0, 0);
        check("seq2_instr", bus.if_id_instr, 32'h34246163);
        check("seq2_pc4",   bus.if_id_pc_plus4, 32'h8);
        cycle(0, 0, 0, 0, 0, 0);
        check("seq3_addr",  bus.imem_addr,   32'hC);
        check("seq3_fc",    bus.fetch_count, 32'd3);
        cycle(0, 0, 0, 0, 0, 0);
        check("seq4_addr",  bus.imem_addr,   32'h10);

        // Two stall cycles at pc=0x10, then release.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("stall_addr", bus.imem_addr,   32'h10);
        check("stall_sc",   bus.stall_count, 32'd2);
        check("stall_fc",   bus.fetch_count, 32'd4);
        check("stall_pc4",  bus.if_id_pc_plus4, 32'h10);
        cycle(0, 0, 0, 0, 0, 0);
        check("resume_addr", bus.imem_addr, 32'h14);

        // Branch beats a simultaneous stall.
        cycle(1, 0, 0, 1, 32'h000000F3, 0);
        check("br_stall_addr",  bus.imem_addr, 32'hF0);
        check("br_stall_valid", {31'h0, bus.if_id_valid}, 32'h0);
        check("br_stall_sc",    bus.stall_count, 32'd2);

        // Stalled jump held, then taken.
        cycle(1, 1, 32'h00000244, 0, 0, 0);
        check("jmp_stall_addr", bus.imem_addr, 32'hF0);
        cycle(0, 1, 32'h00000244, 0, 0, 0);
        check("jmp_addr",  bus.imem_addr, 32'h244);
        check("jmp_valid", {31'h0, bus.if_id_valid}, 32'h0);
        cycle(0, 0, 0, 0, 0, 0);

        // Exception overrides branch and jump.
        cycle(0, 1, 32'h00000400, 1, 32'h00000300, 1);
        check("exc_addr", bus.imem_addr, EXC_VEC);
        cycle(0, 0, 0, 0, 0, 0);

        // Back-to-back redirects: second one wins.
        cycle(0, 0, 0, 1, 32'h00000101, 0);
        cycle(0, 1, 32'h00000202, 0, 0, 0);
        check("b2b_addr", bus.imem_addr, 32'h200);
        cycle(0, 0, 0, 0, 0, 0);

        // PC wrap at the top of the address space.
        cycle(0, 0, 0, 1, 32'hFFFFFFFF, 0);
        check("wrap_pre_addr", bus.imem_addr, 32'hFFFFFFFC);
        cycle(0, 0, 0, 0, 0, 0);
        check("wrap_addr", bus.imem_addr, 32'h0);
        check("wrap_pc4",  bus.if_id_pc_plus4, 32'h0);
        check("wrap_valid", {31'h0, bus.if_id_valid}, 32'h1);

        // Asynchronous reset between edges.
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        reset_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
